adder_64: RTL and testbench

Pipelined 64-bit integer adder with carry-in, carry-out and a per-byte carry-chain mask, so one datapath serves full-width and packed SIMD byte-lane addition. It sits in the execution stage as the integer add/sub datapath. Operands arrive with a `valid` strobe and results leave two enabled clock cycles later with a `rdy` strobe.

---
 rtl/adder_64_pkg.sv | 10 +
 rtl/adder_64_lane8.sv | 21 ++
 rtl/adder_64.sv | 134 +++++++++++++
 tb/tb_adder_64.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_64_pkg.sv
// Shared constants for the 64-bit lane-segmented adder: data width, lane geometry
// and the carry-mask width.
package adder_64_pkg;
    localparam int LEN_DATA   = 64;
    localparam int LANE_W     = 8;
    localparam int N_LANES    = LEN_DATA / LANE_W;
    localparam int LEN_MASK   = N_LANES;
    localparam int HALF_LANES = N_LANES / 2;
    localparam int HALF_W     = LEN_DATA / 2;
endpackage

// File: rtl/adder_64_lane8.sv
// adder_lane8: one 8-bit lane of the segmented adder; the active-low mask bit
// kills the incoming carry so the lane can start a fresh packed element.
module adder_lane8
    import adder_64_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              cin,
    input  logic              cmsk_n,
    output logic [LANE_W-1:0] sum,
    output logic              cout
);
    logic [LANE_W:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{LANE_W{1'b0}}, cin & cmsk_n};
    end

    assign sum  = total[LANE_W-1:0];
    assign cout = total[LANE_W];
endmodule

// File: rtl/adder_64.sv
// adder_64: two-stage pipelined 64-bit adder built from eight 8-bit lanes.
// Define ADDER64_SIMD_EN to honour cmsk_n; otherwise the carry chain is always full width.
module adder_64
    import adder_64_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                valid,
    input  logic [LEN_DATA-1:0] a,
    input  logic [LEN_DATA-1:0] b,
    input  logic                cin,
    input  logic [LEN_MASK-1:0] cmsk_n,
    output logic [LEN_DATA-1:0] sum,
    output logic                cout,
    output logic                rdy
);
    // Handshake: valid is taken on an edge with en=1 and has no backpressure;
    // rdy pulses for one enabled cycle two enabled edges later, and everything
    // (rdy included) holds while en=0.

    logic [HALF_LANES-1:0] msk_lo;
    logic [HALF_LANES-1:0] msk_hi;
    logic [HALF_LANES:0]   c_lo;
    logic [HALF_LANES:0]   c_hi;
    logic [HALF_W-1:0]     sum_lo;
    logic [HALF_W-1:0]     sum_hi;

    logic                s1_valid_q, s1_valid_d;
    logic [HALF_W-1:0]   s1_sum_lo_q, s1_sum_lo_d;
    logic                s1_c3_q, s1_c3_d;
    logic [HALF_W-1:0]   s1_a_hi_q, s1_a_hi_d;
    logic [HALF_W-1:0]   s1_b_hi_q, s1_b_hi_d;
    logic [LEN_DATA-1:0] sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                rdy_q, rdy_d;

`ifdef ADDER64_SIMD_EN
    logic [HALF_LANES-1:0] s1_msk_hi_q, s1_msk_hi_d;

    assign msk_lo = cmsk_n[HALF_LANES-1:0];
    assign msk_hi = s1_msk_hi_q;

    always_comb begin
        s1_msk_hi_d = s1_msk_hi_q;
        if (en) s1_msk_hi_d = cmsk_n[LEN_MASK-1:HALF_LANES];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s1_msk_hi_q <= '0;
        else      s1_msk_hi_q <= s1_msk_hi_d;
    end
`else
    logic cmsk_n_unused;
    assign cmsk_n_unused = ^cmsk_n;
    assign msk_lo = '1;
    assign msk_hi = '1;
`endif

    // Stage 1 lanes work on live operands; stage 2 lanes on the registered upper half.
    assign c_lo[0] = cin;
    for (genvar i = 0; i < HALF_LANES; i++) begin : g_lo
        adder_lane8 u_lane (
            .a      (a[i*LANE_W +: LANE_W]),
            .b      (b[i*LANE_W +: LANE_W]),
            .cin    (c_lo[i]),
            .cmsk_n (msk_lo[i]),
            .sum    (sum_lo[i*LANE_W +: LANE_W]),
            .cout   (c_lo[i+1])
        );
    end

    assign c_hi[0] = s1_c3_q;
    for (genvar i = 0; i < HALF_LANES; i++) begin : g_hi
        adder_lane8 u_lane (
            .a      (s1_a_hi_q[i*LANE_W +: LANE_W]),
            .b      (s1_b_hi_q[i*LANE_W +: LANE_W]),
            .cin    (c_hi[i]),
            .cmsk_n (msk_hi[i]),
            .sum    (sum_hi[i*LANE_W +: LANE_W]),
            .cout   (c_hi[i+1])
        );
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_lo_d = s1_sum_lo_q;
        s1_c3_d     = s1_c3_q;
        s1_a_hi_d   = s1_a_hi_q;
        s1_b_hi_d   = s1_b_hi_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        rdy_d       = rdy_q;
        if (en) begin
            s1_valid_d  = valid;
            s1_sum_lo_d = sum_lo;
            s1_c3_d     = c_lo[HALF_LANES];
            s1_a_hi_d   = a[LEN_DATA-1:HALF_W];
            s1_b_hi_d   = b[LEN_DATA-1:HALF_W];
            rdy_d       = s1_valid_q;
            // Outputs keep the last result across idle cycles.
            if (s1_valid_q) begin
                sum_d  = {sum_hi, s1_sum_lo_q};
                cout_d = c_hi[HALF_LANES];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_sum_lo_q <= '0;
            s1_c3_q     <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_b_hi_q   <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_lo_q <= s1_sum_lo_d;
            s1_c3_q     <= s1_c3_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            rdy_q       <= rdy_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign rdy  = rdy_q;
endmodule

// File: tb/tb_adder_64.sv
// Self-checking bench for adder_64: directed carry/mask cases plus randomized
// streaming with a stall, checked against a per-byte arithmetic reference model.
module tb_adder_64;
    logic        clk;
    logic        rst;
    logic        en;
    logic        valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [7:0]  cmsk_n;
    logic [63:0] sum;
    logic        cout;
    logic        rdy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard: expected {cout,sum} and the enabled-edge count at which each is due.
    logic [64:0] exp_q[$];
    int          due_q[$];
    int          en_edges;
    logic        exp_rdy;
    logic [63:0] exp_sum;
    logic        exp_cout;
    int          valid_cnt;
    int          rdy_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    adder_64 dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .valid  (valid),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .cmsk_n (cmsk_n),
        .sum    (sum),
        .cout   (cout),
        .rdy    (rdy)
    );

    function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                            input logic ci, input logic [7:0] m);
        logic [7:0]  mm;
        logic [8:0]  t;
        logic        carry;
        logic [63:0] s;
        mm = m;
`ifndef ADDER64_SIMD_EN
        mm = 8'hFF;
`endif
        carry = ci & mm[0];
        s = '0;
        for (int i = 0; i < 8; i++) begin
            t = {1'b0, x[i*8 +: 8]} + {1'b0, y[i*8 +: 8]} + {8'b0, carry};
            s[i*8 +: 8] = t[7:0];
            carry = t[8];
            if (i < 7) carry = carry & mm[i+1];
        end
        return {carry, s};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        due_q.delete();
        en_edges  = 0;
        exp_rdy   = 1'b0;
        exp_sum   = '0;
        exp_cout  = 1'b0;
        valid_cnt = 0;
        rdy_cnt   = 0;
    endtask

    // Drives one cycle from a negedge, advances the model, returns at the next negedge.
    task automatic drive_cycle(input logic v, input logic [63:0] x, input logic [63:0] y,
                               input logic ci, input logic [7:0] m, input logic e);
        valid = v; a = x; b = y; cin = ci; cmsk_n = m; en = e;
        if (e && v) begin
            exp_q.push_back(ref_add(x, y, ci, m));
            due_q.push_back(en_edges + 2);
            valid_cnt++;
        end
        @(posedge clk);
        if (e) begin
            en_edges++;
            exp_rdy = 1'b0;
            if (due_q.size() > 0 && due_q[0] == en_edges) begin
                {exp_cout, exp_sum} = exp_q.pop_front();
                void'(due_q.pop_front());
                exp_rdy = 1'b1;
            end
        end
        @(negedge clk);
        if (e && rdy) rdy_cnt++;
    endtask

    task automatic test_reset();
        logic [63:0] x, y;
        logic        ci;
        logic [7:0]  m;
        logic [64:0] r;
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; en = 1'b1;
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1)); cmsk_n = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (sum !== 64'd0) begin tests_failed++; $display("FAIL reset_sum: got %h want 0", sum); end
            tests_run++;
            if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout: got %b want 0", cout); end
            tests_run++;
            if (rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        end
        rst = 1'b1;
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        ci = 1'($urandom_range(0, 1)); m = 8'($urandom);
        r = ref_add(x, y, ci, m);
        drive_cycle(1'b1, x, y, ci, m, 1'b1);
        tests_run++;
        if (rdy !== 1'b0) begin tests_failed++; $display("FAIL first_lat1: rdy got %b want 0", rdy); end
        drive_cycle(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1);
        tests_run++;
        if (rdy !== 1'b1 || {cout, sum} !== r) begin
            tests_failed++;
            $display("FAIL first_lat2: rdy=%b res=%h want rdy=1 res=%h", rdy, {cout, sum}, r);
        end
        // Reset asserted mid-flight discards both outstanding operations.
        drive_cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 8'hFF, 1'b1);
        drive_cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 8'hFF, 1'b1);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({rdy, cout, sum} !== 66'd0) begin
            tests_failed++;
            $display("FAIL async_reset: rdy=%b cout=%b sum=%h want all 0", rdy, cout, sum);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1);
            tests_run++;
            if (rdy !== 1'b0) begin tests_failed++; $display("FAIL inflight_discard: rdy got %b want 0", rdy); end
        end
    endtask

    task automatic test_full_carry();
        drive_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 8'hFF, 1'b1);
        tests_run++;
        if (rdy !== 1'b0) begin tests_failed++; $display("FAIL full_carry_early: rdy got %b want 0", rdy); end
        drive_cycle(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1);
        tests_run++;
        if (rdy !== 1'b1 || sum !== 64'd0 || cout !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_carry: rdy=%b sum=%h cout=%b want 1/0/1", rdy, sum, cout);
        end
        drive_cycle(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1);
        tests_run++;
        if (rdy !== 1'b0 || sum !== 64'd0 || cout !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_carry_hold: rdy=%b sum=%h cout=%b want 0/0/1", rdy, sum, cout);
        end
    endtask

    task automatic test_byte_simd();
        logic [63:0] want_sum;
        logic        want_cout;
`ifdef ADDER64_SIMD_EN
        want_sum = 64'hFFFF_FFFF_FFFF_FF00; want_cout = 1'b0;
`else
        want_sum = 64'd0; want_cout = 1'b1;
`endif
        drive_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 8'h00, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1);
        tests_run++;
        if (rdy !== 1'b1 || sum !== want_sum || cout !== want_cout) begin
            tests_failed++;
            $display("FAIL byte_simd: rdy=%b sum=%h cout=%b want 1/%h/%b", rdy, sum, cout, want_sum, want_cout);
        end
    endtask

    task automatic test_cin_gating();
        logic [63:0] want_masked;
`ifdef ADDER64_SIMD_EN
        want_masked = 64'd0;
`else
        want_masked = 64'd1;
`endif
        drive_cycle(1'b1, 64'd0, 64'd0, 1'b1, 8'hFE, 1'b1);
        drive_cycle(1'b1, 64'd0, 64'd0, 1'b1, 8'hFF, 1'b1);
        tests_run++;
        if (rdy !== 1'b1 || sum !== want_masked) begin
            tests_failed++;
            $display("FAIL cin_masked: rdy=%b sum=%h want 1/%h", rdy, sum, want_masked);
        end
        drive_cycle(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1);
        tests_run++;
        if (rdy !== 1'b1 || sum !== 64'd1) begin
            tests_failed++;
            $display("FAIL cin_pass: rdy=%b sum=%h want 1/1", rdy, sum);
        end
        drive_cycle(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1);
    endtask

    task automatic test_mid_chain();
        logic [63:0] want_sum;
`ifdef ADDER64_SIMD_EN
        want_sum = 64'd0;
`else
        want_sum = 64'h0000_0001_0000_0000;
`endif
        drive_cycle(1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 8'hEF, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 8'hFF, 1'b1);
        tests_run++;
        if (rdy !== 1'b1 || sum !== want_sum || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_chain: rdy=%b sum=%h cout=%b want 1/%h/0", rdy, sum, cout, want_sum);
        end
    endtask

    task automatic test_stream(input logic every_cycle);
        logic [63:0] x, y;
        logic        v, e;
        valid_cnt = 0;
        rdy_cnt   = 0;
        for (int c = 0; c < 43; c++) begin
            v = every_cycle ? 1'b1 : (c % 2 == 0);
            e = !(c >= 20 && c < 23);
            if (c >= 40) v = 1'b0;
            x = {$urandom, $urandom};
            y = ($urandom_range(0, 3) == 0) ? ~x : {$urandom, $urandom};
            drive_cycle(v, x, y, 1'($urandom_range(0, 1)), 8'($urandom), e);
            tests_run++;
            if (rdy !== exp_rdy || sum !== exp_sum || cout !== exp_cout) begin
                tests_failed++;
                $display("FAIL stream%0d_c%0d: rdy=%b sum=%h cout=%b want rdy=%b sum=%h cout=%b",
                         every_cycle, c, rdy, sum, cout, exp_rdy, exp_sum, exp_cout);
            end
        end
        tests_run++;
        if (rdy_cnt !== valid_cnt || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stream%0d_count: rdy pulses=%0d want %0d (pending %0d)",
                     every_cycle, rdy_cnt, valid_cnt, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; valid = 1'b0; a = '0; b = '0; cin = 1'b0; cmsk_n = 8'hFF;
        #1;
        test_reset();
        test_full_carry();
        test_byte_simd();
        test_cin_gating();
        test_mid_chain();
        test_stream(1'b0);
        test_stream(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
